pattern_tx: RTL and testbench

Serial pattern transmitter for the "0→1" sequence-detector FSMs in the state-machine exercise set. It accepts a W-bit word on a start handshake and emits a two-bit "00" preamble followed by the word MSB-first on a single serial line. While shifting, it counts the rising "0→1" transitions it sends, so the bench and the loopback detector can compare pulse counts against `exp_cnt`. It sits upstream of the detector, driving the detector's serial `in` from the same `clk`.

---
 rtl/pattern_tx_if.sv | 22 ++
 rtl/pattern_tx.sv | 105 ++++++++++
 tb/tb_pattern_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pattern_tx_if.sv
// Handshake and serial-line bundle between a frame requester and pattern_tx.
// The master side requests frames; the slave side (pattern_tx) serialises them.
interface pattern_tx_if #(
  parameter int W = 8
);
  logic                     start;
  logic [W-1:0]             data;
  logic                     out;
  logic                     busy;
  logic                     done;
  logic [$clog2(W+1)-1:0]   exp_cnt;

  modport master (
    output start, data,
    input  out, busy, done, exp_cnt
  );

  modport slave (
    input  start, data,
    output out, busy, done, exp_cnt
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: "00" preamble then a W-bit word MSB-first,
// counting the 0->1 transitions it sends so a loopback detector can be checked.
module pattern_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  pattern_tx_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    PRE0,
    PRE1,
    DATA,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    sr;
  logic [BW-1:0]   bit_cnt;
  logic            prev_bit;
  logic            out_q;
  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   cnt_q;
  logic            emit;
  logic            rise;

  // A data bit leaves the shift register on the PRE1 edge and on every DATA
  // edge except the last, which instead moves to DONE.
  assign emit = (state == PRE1) || ((state == DATA) && (bit_cnt != '0));
  assign rise = sr[W-1] & ~prev_bit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is
      // cleared with everything else to give a fully defined post-reset state.
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      prev_bit <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          out_q  <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= PRE0;
            busy_q   <= 1'b1;
            sr       <= bus.data;
            cnt_q    <= '0;
            prev_bit <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        PRE0: state <= PRE1;
        PRE1: begin
          state   <= DATA;
          bit_cnt <= BW'(W - 1);
        end
        DATA: begin
          if (bit_cnt == '0) begin
            state  <= DONE;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          out_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase

      if (emit) begin
        out_q    <= sr[W-1];
        prev_bit <= sr[W-1];
        sr       <= {sr[W-2:0], 1'b0};
        if (rise) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.exp_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: frame timing, transition counts, busy/start
// interaction, asynchronous clear and a loopback 0->1 detector over random words.
module tb_pattern_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic det_prev = 1'b0;
  logic [3:0] last_exp = '0;

  pattern_tx_if #(.W(W)) bus ();

  pattern_tx #(.W(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_rises(input logic [W-1:0] d);
    int   n = 0;
    logic p = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i] && !p) n++;
      p = d[i];
    end
    return n;
  endfunction

  // Called at the negedge of cycle k+1 (first cycle after the accepting edge).
  // Checks the 10 line bits, busy, the DONE cycle and a behavioural detector.
  task automatic expect_frame(input logic [W-1:0] d, input bit poke);
    int   pulses = 0;
    logic eb;
    for (int i = 0; i < W + 2; i++) begin
      if (i > 0) @(negedge clk);
      if (poke && i == 5) begin
        bus.start = 1'b1;
        bus.data  = ~d;
      end
      if (poke && i == 6) bus.start = 1'b0;
      eb = (i < 2) ? 1'b0 : d[W + 1 - i];
      check($sformatf("out[%0d] d=%0h", i, d), {31'd0, bus.out}, {31'd0, eb});
      check("busy in frame", {31'd0, bus.busy}, 32'd1);
      if (i < 2) check("no pulse in preamble", {31'd0, bus.out & ~det_prev}, 32'd0);
      if (bus.out && !det_prev) pulses++;
      det_prev = bus.out;
    end
    @(negedge clk);
    check("done pulse", {31'd0, bus.done}, 32'd1);
    check("busy in done", {31'd0, bus.busy}, 32'd0);
    check("out in done", {31'd0, bus.out}, 32'd0);
    check($sformatf("exp_cnt d=%0h", d), 32'(bus.exp_cnt), 32'(ref_rises(d)));
    check("detector pulses", 32'(pulses), 32'(bus.exp_cnt));
    det_prev = bus.out;
    last_exp = 4'(ref_rises(d));
  endtask

  task automatic kick(input logic [W-1:0] d, input bit poke);
    bus.start = 1'b1;
    bus.data  = d;
    @(negedge clk);
    bus.start = 1'b0;
    expect_frame(d, poke);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle busy", {31'd0, bus.busy}, 32'd0);
    check("idle done", {31'd0, bus.done}, 32'd0);
    check("idle out", {31'd0, bus.out}, 32'd0);
    check("exp_cnt held", 32'(bus.exp_cnt), 32'(last_exp));
  endtask

  initial begin
    logic [W-1:0] d;
    bus.start = 1'b1;
    bus.data  = 8'hA5;

    // Clear held with start asserted: nothing may move.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst out", {31'd0, bus.out}, 32'd0);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
      check("rst exp_cnt", 32'(bus.exp_cnt), 32'd0);
    end
    bus.start = 1'b0;
    clr = 1'b1;
    idle_cycle();

    kick(8'hA5, 1'b0);
    idle_cycle();
    kick(8'hFF, 1'b0);
    idle_cycle();
    kick(8'h00, 1'b0);
    idle_cycle();
    kick(8'h55, 1'b0);
    idle_cycle();

    // Back-to-back: start held, data changed mid-frame for the next word.
    bus.start = 1'b1;
    bus.data  = 8'hAA;
    @(negedge clk);
    bus.data  = 8'h01;
    expect_frame(8'hAA, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    expect_frame(8'h01, 1'b0);
    idle_cycle();

    // Start pulse and data change during DATA are ignored.
    kick(8'h3C, 1'b1);
    idle_cycle();

    // Asynchronous clear mid-DATA.
    bus.start = 1'b1;
    bus.data  = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-clr out", {31'd0, bus.out}, 32'd1);
    #2 clr = 1'b0;
    #1;
    check("clr out", {31'd0, bus.out}, 32'd0);
    check("clr busy", {31'd0, bus.busy}, 32'd0);
    check("clr done", {31'd0, bus.done}, 32'd0);
    check("clr exp_cnt", 32'(bus.exp_cnt), 32'd0);
    det_prev = 1'b0;
    last_exp = '0;
    @(negedge clk);
    clr = 1'b1;
    idle_cycle();
    kick(8'hA5, 1'b0);

    // Loopback over random words, mixing idle gaps and back-to-back frames.
    for (int n = 0; n < 64; n++) begin
      d = W'($urandom);
      if ($urandom_range(0, 1) == 0) idle_cycle();
      bus.start = 1'b1;
      bus.data  = d;
      @(negedge clk);
      bus.start = 1'b0;
      expect_frame(d, 1'b0);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
